// File: rtl/seg_scan_capture.sv
// Receive side of a scanned, active-low 7-segment display bus. Each digit's pattern is filtered
// for stability and decoded back to BCD. Complete frames are presented on a valid/ready interface.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    overrun
);

    localparam int            CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 2);

    typedef enum logic {SCAN, PRESENT} state_t;

    // {err, bcd}: blank is a legal pattern, anything unrecognised is flagged
    function automatic logic [4:0] decode7(input logic [6:0] s);
        case (s)
            7'h40:   decode7 = 5'h00;
            7'h79:   decode7 = 5'h01;
            7'h24:   decode7 = 5'h02;
            7'h30:   decode7 = 5'h03;
            7'h19:   decode7 = 5'h04;
            7'h12:   decode7 = 5'h05;
            7'h02:   decode7 = 5'h06;
            7'h78:   decode7 = 5'h07;
            7'h00:   decode7 = 5'h08;
            7'h10:   decode7 = 5'h09;
            7'h7F:   decode7 = 5'h0F;
            default: decode7 = 5'h1E;
        endcase
    endfunction

    logic [7:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic [NUM_DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] work_bcd_q, work_bcd_d;
    logic [NUM_DIGITS-1:0]   work_dp_q, work_dp_d, work_err_q, work_err_d;
    state_t                  state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d, err_out_q, err_out_d;
    logic                    overrun_q, overrun_d;

    logic [3:0]              low_cnt;
    logic                    sample_ok, same, cap, seen_clr, seen_full;
    logic [NUM_DIGITS-1:0]   cap_mask;
    logic [4:0]              dec;

    assign seen_full = &seen_q;

    always_comb begin
        seg_s1_d   = seg_in;
        an_s1_d    = an_in;
        seg_s2_d   = seg_s1_q;
        an_s2_d    = an_s1_q;
        seg_prev_d = seg_s2_q;
        an_prev_d  = an_s2_q;
    end

    // Stability filter and capture into the working slots
    always_comb begin
        low_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            low_cnt = low_cnt + {3'b000, ~an_s2_q[i]};
        end
        sample_ok = (low_cnt == 4'd1);
        same      = sample_ok && (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);

        if (!same)                cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                      cnt_d = cnt_q + CW'(1);

        // fires only on the transition into saturation, so once per dwell
        cap      = same && (cnt_q == CNT_ARM);
        cap_mask = cap ? ~an_s2_q : '0;
        dec      = decode7(seg_s2_q[6:0]);

        work_bcd_d = work_bcd_q;
        work_dp_d  = work_dp_q;
        work_err_d = work_err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i]) begin
                work_bcd_d[4*i +: 4] = dec[3:0];
                work_err_d[i]        = dec[4];
                work_dp_d[i]         = ~seg_s2_q[7];
            end
        end
    end

    // Frame FSM: accept takes priority over a simultaneous fill, which then loads next edge
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        bcd_out_d   = bcd_out_q;
        dp_out_d    = dp_out_q;
        err_out_d   = err_out_q;
        overrun_d   = overrun_q;
        seen_clr    = 1'b0;
        case (state_q)
            SCAN: begin
                if (seen_full) begin
                    bcd_out_d   = work_bcd_q;
                    dp_out_d    = work_dp_q;
                    err_out_d   = work_err_q;
                    out_valid_d = 1'b1;
                    seen_clr    = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = SCAN;
                end else if (seen_full) begin
                    overrun_d = 1'b1;
                    seen_clr  = 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
        seen_d = (seen_clr ? '0 : seen_q) | cap_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q    <= '1;
            seg_s2_q    <= '1;
            seg_prev_q  <= '1;
            an_s1_q     <= '1;
            an_s2_q     <= '1;
            an_prev_q   <= '1;
            cnt_q       <= '0;
            seen_q      <= '0;
            work_bcd_q  <= '0;
            work_dp_q   <= '0;
            work_err_q  <= '0;
            state_q     <= SCAN;
            out_valid_q <= 1'b0;
            bcd_out_q   <= '0;
            dp_out_q    <= '0;
            err_out_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            seg_s1_q    <= seg_s1_d;
            seg_s2_q    <= seg_s2_d;
            seg_prev_q  <= seg_prev_d;
            an_s1_q     <= an_s1_d;
            an_s2_q     <= an_s2_d;
            an_prev_q   <= an_prev_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            work_bcd_q  <= work_bcd_d;
            work_dp_q   <= work_dp_d;
            work_err_q  <= work_err_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            bcd_out_q   <= bcd_out_d;
            dp_out_q    <= dp_out_d;
            err_out_q   <= err_out_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_out_q;
    assign dp_out    = dp_out_q;
    assign err_out   = err_out_q;
    assign overrun   = overrun_q;

endmodule
